fb_reader: RTL and testbench
============================

Name: fb_reader

Overview:
- Read side of the frame-buffer BRAM: sweeps read addresses over one full frame and streams the pixels into the 125→25 MHz output FIFO.
- Paces reads on the FIFO almost-full flag and tracks BRAM read latency, so no pixel is lost or duplicated.
- Starts a frame only after the writer has completed one and the display requests data.
- Runs entirely in the i_clk (125 MHz) domain.

Parameters:
- DATA_WIDTH, 12, pixel width.
- BRAM_DEPTH, 307200, pixels per frame (640x480).
- ADDR_WIDTH, 19, read address width; must satisfy 2^ADDR_WIDTH >= BRAM_DEPTH.
- RD_LATENCY, 1, BRAM read latency in cycles; legal range 1..4.

Ports:
- i_clk  in  1  system clock, 125 MHz.
- i_rstn  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous abort; restart from address 0.
- i_frame_ready  in  1  level; writer has stored at least one complete frame.
- i_req  in  1  level; display active, requesting pixels.
- o_raddr  out  ADDR_WIDTH  BRAM read address.
- i_rdata  in  DATA_WIDTH  BRAM read data; valid RD_LATENCY cycles after o_raddr.
- o_wr  out  1  FIFO write enable.
- o_wdata  out  DATA_WIDTH  FIFO write data.
- i_almostfull  in  1  FIFO almost-full flag.
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is written to the FIFO.

Behaviour:
- Reset (async assert, sync release) drives the following:
  - state = IDLE.
  - o_raddr = 0, o_wr = 0, o_wdata = 0, o_frame_done = 0.
  - pipeline valid shift register cleared.
- States:
  - IDLE: go to WAIT_REQ when i_frame_ready = 1.
  - WAIT_REQ: go to ACTIVE when i_req = 1. The address stays 0.
  - ACTIVE: a read is issued in any cycle where i_almostfull = 0.
    - Each issued read shifts a 1 into a RD_LATENCY-deep valid pipeline.
    - Each issued read advances o_raddr on the next edge.
    - Issuing address BRAM_DEPTH-1 wraps o_raddr to 0 and moves to DRAIN.
    - No read is issued in a cycle with i_almostfull = 1; o_raddr holds.
  - DRAIN: issue no reads. When the valid pipeline is empty, pulse o_frame_done for 1 cycle and return to WAIT_REQ.
- i_req deasserting during ACTIVE does not pause reading. Flow control is solely i_almostfull.
- Output timing:
  - o_wr = valid pipeline output, registered.
  - o_wdata = i_rdata, registered in the same cycle o_wr is set.
  - Read issued at cycle N gives o_wr = 1 at cycle N+RD_LATENCY+1.
  - o_wr is a single-cycle strobe per pixel, never held.
- In-flight reads complete even if i_almostfull rises. The FIFO almost-full threshold must leave at least RD_LATENCY+1 free entries.
- Exactly BRAM_DEPTH o_wr pulses per frame, at addresses 0..BRAM_DEPTH-1 in ascending order.
- o_frame_done coincides with the cycle after the final o_wr.
- i_flush (highest priority below reset):
  - next edge forces state = IDLE, o_raddr = 0.
  - clears the valid pipeline; o_wr = 0 from that edge on, and in-flight data is discarded.
  - o_frame_done is suppressed.
- i_frame_ready is sampled only in IDLE. Dropping it later does not abort a frame.
- Simultaneous last read and i_almostfull rising: the last read still issues, because the read decision uses the current-cycle flag.
- o_raddr never exceeds BRAM_DEPTH-1.

Test Plan:
- Small-frame free run:
  - Setup: BRAM_DEPTH=16, RD_LATENCY=1, BRAM model returns data = address; i_frame_ready=1, i_req=1, i_almostfull=0.
  - Required: 16 consecutive o_wr pulses with o_wdata 0..15; first o_wr 2 cycles after the first read issue; o_frame_done exactly 1 cycle after o_wdata=15; state returns to WAIT_REQ with o_raddr=0.
- Backpressure:
  - Stimulus: hold i_almostfull=1 for 5 cycles mid-frame at address 7.
  - Required: o_raddr holds at 7 for 5 cycles; the in-flight pixel 6 is still written; the sequence stays 0..15 with no gaps or duplicates.
- Flush mid-frame:
  - Stimulus: i_flush at address 9.
  - Required: o_wr=0 from the next edge; o_raddr=0; no o_frame_done.
  - Follow-up: after the flush, with i_frame_ready and i_req still high, the next frame restarts at address 0.
- Gating:
  - Stimulus: i_req=1 while i_frame_ready=0.
  - Required: no reads issued and o_wr stays 0; reading starts 2 cycles after i_frame_ready rises.
- Async reset mid-frame:
  - Stimulus: drop i_rstn between clock edges.
  - Required: outputs zero immediately, without waiting for an edge.
- Latency sweep:
  - Stimulus: RD_LATENCY=3 with random i_almostfull toggling over 3 frames.
  - Required: 48 writes in the correct order and 3 o_frame_done pulses.

Source files
------------

// File: rtl/fb_reader_if.sv
// Bus bundle between the frame-buffer reader, the frame-buffer BRAM read port
// and the write side of the output FIFO. Signal names keep the direction
// prefixes as seen from the reader.
interface fb_reader_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19
);
  logic [ADDR_WIDTH-1:0] o_raddr;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  o_wr;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic                  i_almostfull;

  modport master (
    output o_raddr,
    input  i_rdata,
    output o_wr,
    output o_wdata,
    input  i_almostfull
  );

  modport slave (
    input  o_raddr,
    output i_rdata,
    input  o_wr,
    input  o_wdata,
    output i_almostfull
  );
endinterface

// File: rtl/fb_reader.sv
// Frame-buffer read side: sweeps the BRAM once per frame and streams pixels
// into the output FIFO. Reads are paced on the FIFO almost-full flag, and a
// short valid pipeline matching the BRAM latency marks which returning words
// are real pixels, so nothing is lost or written twice.
module fb_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int BRAM_DEPTH = 307200,
  parameter int ADDR_WIDTH = 19,
  parameter int RD_LATENCY = 1
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_flush,
  input  logic         i_frame_ready,
  input  logic         i_req,
  fb_reader_if.master  bus,
  output logic         o_frame_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BRAM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_REQ,
    ACTIVE,
    DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [RD_LATENCY-1:0]   vld_q, vld_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    done_q, done_d;
  logic                    issue;

  // Frame sequencing and read issue; the read decision uses the current-cycle
  // almost-full flag, and flush overrides everything back to an idle restart.
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_frame_ready) state_d = WAIT_REQ;
      end
      WAIT_REQ: begin
        if (i_req) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!bus.i_almostfull) begin
          issue = 1'b1;
          if (raddr_q == LAST_ADDR) begin
            raddr_d = '0;
            state_d = DRAIN;
          end else begin
            raddr_d = raddr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (vld_q == '0) begin
          done_d  = 1'b1;
          state_d = WAIT_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (i_flush) begin
      state_d = IDLE;
      raddr_d = '0;
      done_d  = 1'b0;
      issue   = 1'b0;
    end
  end

  // Valid pipeline tracks reads in flight; its output captures the BRAM word
  // into the FIFO write register. Flush discards everything still in flight.
  always_comb begin
    vld_d   = RD_LATENCY'({vld_q, issue});
    wr_d    = vld_q[RD_LATENCY-1];
    wdata_d = vld_q[RD_LATENCY-1] ? bus.i_rdata : wdata_q;
    if (i_flush) begin
      vld_d   = '0;
      wr_d    = 1'b0;
      wdata_d = wdata_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      raddr_q <= '0;
      vld_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_raddr  = raddr_q;
  assign bus.o_wr     = wr_q;
  assign bus.o_wdata  = wdata_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_fb_reader.sv
// Bench for fb_reader: two instances on a 16-pixel frame (read latency 1 and
// 3) share one stimulus stream. A transaction-level model predicts addresses,
// FIFO writes and frame-done pulses; directed literal checks pin the model.
module tb_fb_reader;

  localparam int DW    = 12;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rstn, flush, frame_ready, req, almostfull;
  logic done0, done1;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fb_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  fb_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  fb_reader #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_frame_ready(frame_ready),
    .i_req(req), .bus(bus0), .o_frame_done(done0));

  fb_reader #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LATENCY(3)) dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_frame_ready(frame_ready),
    .i_req(req), .bus(bus1), .o_frame_done(done1));

  // BRAM models: data equals address, delivered 1 and 3 cycles after the address
  logic [AW-1:0] pipe0;
  logic [AW-1:0] pipe1 [3];
  always @(posedge clk) pipe0 <= bus0.o_raddr;
  always @(posedge clk) begin
    pipe1[0] <= bus1.o_raddr;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign bus0.i_rdata      = DW'(pipe0);
  assign bus1.i_rdata      = DW'(pipe1[2]);
  assign bus0.i_almostfull = almostfull;
  assign bus1.i_almostfull = almostfull;

  logic [AW-1:0] raddr_w [2];
  logic          wr_w    [2];
  logic [DW-1:0] wdata_w [2];
  logic          done_w  [2];
  always_comb begin
    raddr_w[0] = bus0.o_raddr;  raddr_w[1] = bus1.o_raddr;
    wr_w[0]    = bus0.o_wr;     wr_w[1]    = bus1.o_wr;
    wdata_w[0] = bus0.o_wdata;  wdata_w[1] = bus1.o_wdata;
    done_w[0]  = done0;         done_w[1]  = done1;
  end

  // ---------------- behavioural model ----------------
  bit ready_seen [2];
  bit reading    [2];
  bit draining   [2];
  bit done_next  [2];
  int exp_raddr  [2];
  bit exp_wr     [2];
  int exp_wdata  [2];
  bit exp_done   [2];
  int pend_addr  [2][8];
  int pend_rem   [2][8];
  int pend_n     [2];
  int wr_cnt     [2];
  int done_cnt   [2];

  function automatic int latency(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic model_clear(input int g, input bit full);
    ready_seen[g] = 0; reading[g] = 0; draining[g] = 0; done_next[g] = 0;
    exp_raddr[g] = 0; exp_wr[g] = 0; exp_done[g] = 0; pend_n[g] = 0;
    if (full) exp_wdata[g] = 0;
  endtask

  // One clock edge of the frame sweep: reads come back as writes after
  // latency+1 cycles, in issue order; done follows the write of the last pixel.
  task automatic model_step(input int g);
    bit was_done;
    if (flush) begin
      model_clear(g, 1'b0);
      return;
    end
    exp_wr[g]    = 0;
    exp_done[g]  = done_next[g];
    was_done     = done_next[g];
    done_next[g] = 0;
    for (int i = 0; i < pend_n[g]; i++) pend_rem[g][i]--;
    if (pend_n[g] > 0 && pend_rem[g][0] == 0) begin
      exp_wr[g]    = 1;
      exp_wdata[g] = pend_addr[g][0];
      if (pend_addr[g][0] == DEPTH - 1) done_next[g] = 1;
      for (int i = 1; i < pend_n[g]; i++) begin
        pend_addr[g][i-1] = pend_addr[g][i];
        pend_rem[g][i-1]  = pend_rem[g][i];
      end
      pend_n[g]--;
    end
    if (!ready_seen[g]) begin
      ready_seen[g] = frame_ready;
    end else if (reading[g]) begin
      if (!almostfull) begin
        pend_addr[g][pend_n[g]] = exp_raddr[g];
        pend_rem[g][pend_n[g]]  = latency(g);
        pend_n[g]++;
        if (exp_raddr[g] == DEPTH - 1) begin
          exp_raddr[g] = 0;
          reading[g]   = 0;
          draining[g]  = 1;
        end else begin
          exp_raddr[g]++;
        end
      end
    end else if (!draining[g]) begin
      reading[g] = req;
    end
    if (was_done) draining[g] = 0;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      model_clear(g, 1'b1);
      wr_cnt[g] = 0;
      done_cnt[g] = 0;
    end
    forever begin
      @(posedge clk or negedge rstn);
      for (int g = 0; g < 2; g++) begin
        if (!rstn) model_clear(g, 1'b1);
        else model_step(g);
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every cycle, both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        check_output($sformatf("lat%0d raddr", latency(g)), 32'(raddr_w[g]), 32'(exp_raddr[g]));
        check_output($sformatf("lat%0d wr", latency(g)), 32'(wr_w[g]), 32'(exp_wr[g]));
        if (exp_wr[g]) check_output($sformatf("lat%0d wdata", latency(g)), 32'(wdata_w[g]), 32'(exp_wdata[g]));
        check_output($sformatf("lat%0d frame_done", latency(g)), 32'(done_w[g]), 32'(exp_done[g]));
        if (wr_w[g] === 1'b1) wr_cnt[g]++;
        if (done_w[g] === 1'b1) done_cnt[g]++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_addr0(input int addr, input int limit);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk); #1;
      if (32'(raddr_w[0]) == addr) found = 1;
    end
    if (!found) begin
      total++; bad++;
      $display("[TB] FAIL wait raddr=%0d: timed out after %0d cycles, want reached", addr, limit);
    end
  endtask

  task automatic wait_done0(input int limit);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk); #1;
      if (done_w[0] === 1'b1) found = 1;
    end
    if (!found) begin
      total++; bad++;
      $display("[TB] FAIL wait frame_done: timed out after %0d cycles, want pulse", limit);
    end
  endtask

  task automatic apply_stimulus();
    bit seen6;
    int snap_wr, snap_done;
    rstn = 1; flush = 0; frame_ready = 0; req = 0; almostfull = 0;
    #1 rstn = 0;
    repeat (3) @(posedge clk);
    #2 rstn = 1;
    @(posedge clk); #1;
    $display("[TB] reset state");
    check_output("reset raddr", 32'(raddr_w[0]), 0);
    check_output("reset wr", 32'(wr_w[0]), 0);
    check_output("reset wdata", 32'(wdata_w[0]), 0);
    check_output("reset done", 32'(done_w[0]), 0);

    $display("[TB] gating on frame_ready");
    req = 1;
    repeat (6) @(posedge clk); #1;
    check_output("gated raddr", 32'(raddr_w[0]), 0);
    check_output("gated writes", 32'(wr_cnt[0] + wr_cnt[1]), 0);
    frame_ready = 1;
    repeat (2) @(posedge clk); #1;
    check_output("start raddr+2", 32'(raddr_w[0]), 0);
    @(posedge clk); #1;
    check_output("start raddr+3", 32'(raddr_w[0]), 1);
    @(posedge clk); #1;
    check_output("first wr", 32'(wr_w[0]), 1);
    check_output("first wdata", 32'(wdata_w[0]), 0);

    $display("[TB] backpressure at address 7");
    wait_addr0(7, 40);
    almostfull = 1;
    seen6 = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      check_output("stall raddr", 32'(raddr_w[0]), 7);
      if (wr_w[0] === 1'b1 && wdata_w[0] == 6) seen6 = 1;
    end
    almostfull = 0;
    check_output("in-flight pixel 6", 32'(seen6), 1);
    wait_done0(100);
    check_output("frame1 writes", 32'(wr_cnt[0]), 16);
    check_output("frame1 done count", 32'(done_cnt[0]), 1);
    check_output("frame1 end raddr", 32'(raddr_w[0]), 0);

    $display("[TB] flush at address 9");
    wait_addr0(9, 40);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    check_output("flush raddr", 32'(raddr_w[0]), 0);
    check_output("flush wr", 32'(wr_w[0]), 0);
    snap_wr = wr_cnt[0];
    snap_done = done_cnt[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_output("post-flush wr", 32'(wr_w[0]), 0);
    end
    wait_done0(100);
    check_output("restart frame writes", 32'(wr_cnt[0] - snap_wr), 16);
    check_output("restart done count", 32'(done_cnt[0] - snap_done), 1);

    $display("[TB] async reset mid-frame");
    repeat (7) @(posedge clk);
    #3 rstn = 0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check_output($sformatf("lat%0d async raddr", latency(g)), 32'(raddr_w[g]), 0);
      check_output($sformatf("lat%0d async wr", latency(g)), 32'(wr_w[g]), 0);
      check_output($sformatf("lat%0d async wdata", latency(g)), 32'(wdata_w[g]), 0);
      check_output($sformatf("lat%0d async done", latency(g)), 32'(done_w[g]), 0);
    end
    repeat (2) @(posedge clk);
    #2 rstn = 1;

    $display("[TB] random almost-full over three frames");
    snap_wr = wr_cnt[1];
    snap_done = done_cnt[1];
    for (int c = 0; c < 3000 && (done_cnt[1] - snap_done) < 3; c++) begin
      @(posedge clk); #2;
      almostfull = ($urandom_range(0, 2) == 0);
    end
    almostfull = 0;
    @(negedge clk); #1;
    check_output("lat3 random writes", 32'(wr_cnt[1] - snap_wr), 48);
    check_output("lat3 random done count", 32'(done_cnt[1] - snap_done), 3);
    repeat (5) @(posedge clk);
  endtask

  initial begin
    apply_stimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
